// File: rtl/val2_shifter_pipe_if.sv
// Handshake bundle between the issue side and the EXE-stage operand-2 shifter.
// The producer/consumer side uses the master view, the shifter the slave view.
interface val2_shifter_pipe_if #(
   parameter int DATA_LEN = 32
);
   logic                in_valid;
   logic                in_ready;
   logic [1:0]          mode;
   logic [11:0]         offset;
   logic [DATA_LEN-1:0] val_rm;
   logic [DATA_LEN-1:0] val_rs;
   logic                c_in;
   logic                out_valid;
   logic                out_ready;
   logic [DATA_LEN-1:0] val2;
   logic                c_out;

   modport master (
      output in_valid, mode, offset, val_rm, val_rs, c_in, out_ready,
      input  in_ready, out_valid, val2, c_out
   );

   modport slave (
      input  in_valid, mode, offset, val_rm, val_rs, c_in, out_ready,
      output in_ready, out_valid, val2, c_out
   );
endinterface

// File: rtl/val2_shifter_pipe.sv
// Two-stage ARM operand-2 generator. Stage 1 decodes the instruction field into a
// normalised (kind, amount, operand) triple so every corner case (amount 0, amount N,
// amount > N, RRX, imm8 rotate, memory offset) becomes one of a few simple operations.
// Stage 2 performs the barrel shift and registers val2 / carry-out.
module val2_shifter_pipe #(
   parameter  int DATA_LEN = 32,
   localparam int SHAMT_W  = $clog2(DATA_LEN)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   val2_shifter_pipe_if.slave bus
);

   typedef enum logic [1:0] {
      MODE_IMM_SH  = 2'b00,
      MODE_REG_SH  = 2'b01,
      MODE_ROT_IMM = 2'b10,
      MODE_MEM_OFS = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      SH_LSL = 2'b00,
      SH_LSR = 2'b01,
      SH_ASR = 2'b10,
      SH_ROR = 2'b11
   } shift_e;

   // Normalised operation carried from stage 1 to stage 2.
   typedef enum logic [3:0] {
      K_PASS,        // operand unchanged, C = c_in
      K_LSL,         // shift by 1..N-1
      K_LSR,
      K_ASR,
      K_ROR,
      K_RRX,         // {c_in, opnd[N-1:1]}, C = opnd[0]
      K_ROR_FULL,    // rotate by a multiple of N: operand unchanged, C = opnd[N-1]
      K_ZERO,        // 0, C = 0
      K_ZERO_C_LSB,  // 0, C = opnd[0]   (LSL by exactly N)
      K_ZERO_C_MSB,  // 0, C = opnd[N-1] (LSR by exactly N)
      K_SIGN         // all copies of opnd[N-1], C = opnd[N-1]
   } kind_e;

   localparam logic [7:0] N_AMT = 8'(DATA_LEN);

   function automatic kind_e shift_kind(input shift_e t);
      case (t)
         SH_LSL:  shift_kind = K_LSL;
         SH_LSR:  shift_kind = K_LSR;
         SH_ASR:  shift_kind = K_ASR;
         default: shift_kind = K_ROR;
      endcase
   endfunction

   mode_e               mode;
   shift_e              sh_type;
   logic [7:0]          rs_amt;
   logic [SHAMT_W-1:0]  imm_amt;
   logic [SHAMT_W-1:0]  rot_amt;
   logic [SHAMT_W-1:0]  rs_mod;
   logic                unused_rs_hi;

   assign mode         = mode_e'(bus.mode);
   assign sh_type      = shift_e'(bus.offset[6:5]);
   assign rs_amt       = bus.val_rs[7:0];
   assign imm_amt      = SHAMT_W'(bus.offset[11:7]);
   assign rot_amt      = SHAMT_W'({bus.offset[11:8], 1'b0});
   assign rs_mod       = rs_amt[SHAMT_W-1:0];
   assign unused_rs_hi = ^bus.val_rs[DATA_LEN-1:8];

   kind_e               d_kind;
   logic [SHAMT_W-1:0]  d_amt;
   logic [DATA_LEN-1:0] d_opnd;

   // Stage-1 decode: map mode/type/amount onto a normalised kind and in-range amount.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      d_kind = K_PASS;
      d_amt  = '0;
      d_opnd = bus.val_rm;
      case (mode)
         MODE_IMM_SH: begin
            if (imm_amt != '0) begin
               d_kind = shift_kind(sh_type);
               d_amt  = imm_amt;
            end else begin
               case (sh_type)
                  SH_LSL:  d_kind = K_PASS;
                  SH_LSR:  d_kind = K_ZERO_C_MSB;
                  SH_ASR:  d_kind = K_SIGN;
                  default: d_kind = K_RRX;
               endcase
            end
         end
         MODE_REG_SH: begin
            if (rs_amt == 8'd0) begin
               d_kind = K_PASS;
            end else if (rs_amt < N_AMT) begin
               d_kind = shift_kind(sh_type);
               d_amt  = rs_mod;
            end else begin
               case (sh_type)
                  SH_LSL:  d_kind = (rs_amt == N_AMT) ? K_ZERO_C_LSB : K_ZERO;
                  SH_LSR:  d_kind = (rs_amt == N_AMT) ? K_ZERO_C_MSB : K_ZERO;
                  SH_ASR:  d_kind = K_SIGN;
                  default: begin
                     if (rs_mod == '0) begin
                        d_kind = K_ROR_FULL;
                     end else begin
                        d_kind = K_ROR;
                        d_amt  = rs_mod;
                     end
                  end
               endcase
            end
         end
         MODE_ROT_IMM: begin
            d_opnd = DATA_LEN'(bus.offset[7:0]);
            if (rot_amt != '0) begin
               d_kind = K_ROR;
               d_amt  = rot_amt;
            end
         end
         default: begin
            d_opnd = DATA_LEN'(bus.offset);
         end
      endcase
   end

   logic                s1_valid;
   kind_e               s1_kind;
   logic [SHAMT_W-1:0]  s1_amt;
   logic [DATA_LEN-1:0] s1_opnd;
   logic                s1_cin;
   logic                s2_valid;
   logic [DATA_LEN-1:0] s2_val2;
   logic                s2_c;
   logic                s1_adv;
   logic                s2_adv;

   assign s2_adv        = !s2_valid || bus.out_ready;
   assign s1_adv        = !s1_valid || s2_adv;
   assign bus.in_ready  = s1_adv;
   assign bus.out_valid = s2_valid;
   assign bus.val2      = s2_val2;
   assign bus.c_out     = s2_c;

   // Stage-1 register: capture the decoded op on an input transfer; flush kills it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: payload is reset along with the valid bit so val2/c_out read 0 from reset.
         s1_valid <= 1'b0;
         s1_kind  <= K_PASS;
         s1_amt   <= '0;
         s1_opnd  <= '0;
         s1_cin   <= 1'b0;
      end else begin
         // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
         if (flush) begin
            s1_valid <= 1'b0;
         end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
         end
         if (s1_adv && bus.in_valid) begin
            s1_kind <= d_kind;
            s1_amt  <= d_amt;
            s1_opnd <= d_opnd;
            s1_cin  <= bus.c_in;
         end
      end
   end

   // Extended shifts: the extra bit catches the last bit shifted out, which is the carry.
   logic [DATA_LEN:0]   lsl_ext;
   logic [DATA_LEN:0]   lsr_ext;
   logic [DATA_LEN:0]   asr_ext;
   logic [DATA_LEN-1:0] ror_res;

   assign lsl_ext = {1'b0, s1_opnd} << s1_amt;
   assign lsr_ext = {s1_opnd, 1'b0} >> s1_amt;
   assign asr_ext = $signed({s1_opnd, 1'b0}) >>> s1_amt;
   assign ror_res = DATA_LEN'({s1_opnd, s1_opnd} >> s1_amt);

   logic [DATA_LEN-1:0] sh_res;
   logic                sh_c;

   // Stage-2 datapath: evaluate the normalised op into result and carry-out.
   always_comb begin
      sh_res = '0;
      sh_c   = 1'b0;
      case (s1_kind)
         K_PASS:       begin sh_res = s1_opnd;                          sh_c = s1_cin;                end
         K_LSL:        begin sh_res = lsl_ext[DATA_LEN-1:0];            sh_c = lsl_ext[DATA_LEN];     end
         K_LSR:        begin sh_res = lsr_ext[DATA_LEN:1];              sh_c = lsr_ext[0];            end
         K_ASR:        begin sh_res = asr_ext[DATA_LEN:1];              sh_c = asr_ext[0];            end
         K_ROR:        begin sh_res = ror_res;                          sh_c = ror_res[DATA_LEN-1];   end
         K_RRX:        begin sh_res = {s1_cin, s1_opnd[DATA_LEN-1:1]};  sh_c = s1_opnd[0];            end
         K_ROR_FULL:   begin sh_res = s1_opnd;                          sh_c = s1_opnd[DATA_LEN-1];   end
         K_ZERO_C_LSB: begin sh_res = '0;                               sh_c = s1_opnd[0];            end
         K_ZERO_C_MSB: begin sh_res = '0;                               sh_c = s1_opnd[DATA_LEN-1];   end
         K_SIGN:       begin sh_res = {DATA_LEN{s1_opnd[DATA_LEN-1]}};  sh_c = s1_opnd[DATA_LEN-1];   end
         default:      begin sh_res = '0;                               sh_c = 1'b0;                  end
      endcase
   end

   // Stage-2 register: load when the slot is free or being drained; hold under back-pressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_val2  <= '0;
         s2_c     <= 1'b0;
      end else begin
         if (flush) begin
            s2_valid <= 1'b0;
         end else if (s2_adv) begin
            s2_valid <= s1_valid;
         end
         if (s2_adv && s1_valid) begin
            s2_val2 <= sh_res;
            s2_c    <= sh_c;
         end
      end
   end

endmodule
